// File: rtl/control_tx_if.sv
// Byte stream from control_tx to the endpoint link model or packetizer.
interface control_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/control_tx.sv
// Debug Class control request transmitter: 8-byte SETUP packet plus optional OUT data stage.
// Define CONTROL_TX_DATA_STAGE_EN to build the host-to-device data stage.
module control_tx (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   bmRequestType,
  input  logic [7:0]   bRequest,
  input  logic [15:0]  wValue,
  input  logic [15:0]  wIndex,
  input  logic [15:0]  wLength,
  input  logic [63:0]  parameter_Block,
  input  logic         abort,
  control_tx_if.master tx,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
`ifdef CONTROL_TX_DATA_STAGE_EN
  localparam logic [1:0] S_DATA  = 2'd2;
`endif
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_inc;
  logic [7:0]  bm_q;
  logic [7:0]  br_q;
  logic [15:0] wv_q;
  logic [15:0] wi_q;
  logic [15:0] wl_q;
  logic [7:0]  setup_nxt;
  logic        has_data;
  logic        xfer;

  assign xfer    = tx.tx_valid && tx.tx_ready;
  assign cnt_inc = cnt + 4'd1;

`ifdef CONTROL_TX_DATA_STAGE_EN
  logic [63:0] pb_q;
  logic [3:0]  cnt_inc2;
  logic [7:0]  data_nxt;

  assign has_data = !bm_q[7] && (wl_q != '0);
  assign cnt_inc2 = cnt + 4'd2;
  assign data_nxt = pb_q[{cnt_inc[2:0], 3'b000} +: 8];
`else
  logic unused_pblock;

  assign has_data      = 1'b0;
  assign unused_pblock = ^parameter_Block;
`endif

  // Next SETUP byte is precomputed so tx_data can stay a plain register.
  always_comb begin
    setup_nxt = '0;
    case (cnt_inc[2:0])
      3'd0: setup_nxt = bm_q;
      3'd1: setup_nxt = br_q;
      3'd2: setup_nxt = wv_q[7:0];
      3'd3: setup_nxt = wv_q[15:8];
      3'd4: setup_nxt = wi_q[7:0];
      3'd5: setup_nxt = wi_q[15:8];
      3'd6: setup_nxt = wl_q[7:0];
      3'd7: setup_nxt = wl_q[15:8];
      default: setup_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bm_q        <= '0;
      br_q        <= '0;
      wv_q        <= '0;
      wi_q        <= '0;
      wl_q        <= '0;
`ifdef CONTROL_TX_DATA_STAGE_EN
      pb_q        <= '0;
`endif
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      tx.tx_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bm_q <= bmRequestType;
            br_q <= bRequest;
            wv_q <= wValue;
            wi_q <= wIndex;
            wl_q <= wLength;
`ifdef CONTROL_TX_DATA_STAGE_EN
            pb_q <= parameter_Block;
            if (!bmRequestType[7] && (wLength > 16'd8)) begin
              err <= 1'b1;
            end else
`endif
            begin
              state       <= S_SETUP;
              cnt         <= '0;
              tx.tx_data  <= bmRequestType;
              tx.tx_valid <= 1'b1;
              tx.tx_last  <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          if (abort) begin
            state       <= S_IDLE;
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            tx.tx_data  <= '0;
            busy        <= 1'b0;
            err         <= 1'b1;
          end else if (xfer) begin
            if (cnt == 4'd7) begin
`ifdef CONTROL_TX_DATA_STAGE_EN
              if (has_data) begin
                state      <= S_DATA;
                cnt        <= '0;
                tx.tx_data <= pb_q[7:0];
                tx.tx_last <= (wl_q == 16'd1);
              end else
`endif
              begin
                state       <= S_DONE;
                tx.tx_valid <= 1'b0;
                tx.tx_last  <= 1'b0;
                tx.tx_data  <= '0;
                done        <= 1'b1;
              end
            end else begin
              cnt        <= cnt_inc;
              tx.tx_data <= setup_nxt;
              tx.tx_last <= (cnt_inc == 4'd7) && !has_data;
            end
          end
        end

`ifdef CONTROL_TX_DATA_STAGE_EN
        S_DATA: begin
          if (abort) begin
            state       <= S_IDLE;
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            tx.tx_data  <= '0;
            busy        <= 1'b0;
            err         <= 1'b1;
          end else if (xfer) begin
            // wLength <= 8 is guaranteed here, so its low nibble is the full byte count.
            if (cnt_inc == wl_q[3:0]) begin
              state       <= S_DONE;
              tx.tx_valid <= 1'b0;
              tx.tx_last  <= 1'b0;
              tx.tx_data  <= '0;
              done        <= 1'b1;
            end else begin
              cnt        <= cnt_inc;
              tx.tx_data <= data_nxt;
              tx.tx_last <= (cnt_inc2 == wl_q[3:0]);
            end
          end
        end
`endif

        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end

        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          tx.tx_valid <= 1'b0;
          tx.tx_last  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/control_tx.md
# control_tx

Host-side transmitter for Debug Class control requests, acting as the initiator for the control endpoint decoder. It takes a request's fields, plus an optional parameter block, as parallel inputs. It serializes them into the standard 8-byte little-endian SETUP packet, followed by an optional host-to-device data stage. Bytes leave on a valid/ready byte stream that feeds the endpoint link model or packetizer.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle launch request, sampled only in IDLE.
- bmRequestType  in  8  request type; bit 7 is direction (0 = host-to-device).
- bRequest  in  8  request code (0x01–0x0A SET, 0x81–0x89 GET).
- wValue  in  16  request value.
- wIndex  in  16  bits 15:8 Debug Unit ID, bits 7:0 interface ID.
- wLength  in  16  data stage length in bytes.
- parameter_Block  in  64  data stage payload; byte k = parameter_Block[8k+7:8k].
- abort  in  1  synchronous abort of an in-flight request.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte; a transfer occurs when tx_valid && tx_ready.
- tx_last  out  1  marks the final byte of the request.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  one-cycle pulse when a request is rejected or aborted.

## Operation
- States: IDLE, SETUP, DATA, DONE.
- IDLE:
  - On start, latch all request fields and parameter_Block.
  - If bmRequestType[7]=0 and wLength>8, pulse err and stay in IDLE; no byte is emitted.
  - Otherwise go to SETUP with the byte counter at 0.
- SETUP: emit 8 bytes in this order:
  - bmRequestType, bRequest
  - wValue[7:0], wValue[15:8]
  - wIndex[7:0], wIndex[15:8]
  - wLength[7:0], wLength[15:8]
- Leaving SETUP, on the transfer of byte 7:
  - Go to DATA if the data stage is enabled, bmRequestType[7]=0 and wLength≠0; the counter resets to 0.
  - Otherwise go to DONE.
- DATA: emit parameter_Block bytes 0..wLength-1, then go to DONE.
- DONE: assert done for one cycle, then return to IDLE.
- Device-to-host requests (bit 7 = 1) never have a data stage here; IN data is handled elsewhere.
- tx_last is asserted with the final byte only:
  - byte 7 of SETUP when there is no data stage;
  - byte wLength-1 of DATA otherwise.
- Byte counter is 4 bits. It increments only on a transfer and never wraps within a request.
- start is ignored while busy=1; no queuing.
- abort in SETUP or DATA: next cycle go to IDLE, drop tx_valid, pulse err, no done. abort in IDLE or DONE has no effect.
- If abort and a transfer occur in the same cycle, the byte counts as accepted and the abort still wins.
- Async reset mid-request discards the request immediately with no done and no err.

## Timing
- Reset values: tx_data=0x00, tx_valid=0, tx_last=0, busy=0, done=0, err=0, FSM in IDLE, counter 0.
- start at edge N → tx_valid=1 with byte 0 from edge N+1.
- Rejection err pulse is in cycle N+1.
- Throughput: with tx_ready held high, one byte per cycle.
- Backpressure: while tx_valid && !tx_ready, tx_data and tx_last hold stable and tx_valid stays high.
- Final transfer at edge M → tx_valid=0 and done=1 in cycle M+1; busy drops at M+2.
- Earliest next accepted start is at edge M+2.
- Every output is registered.

## Configuration
- CONTROL_TX_DATA_STAGE_EN:
  - Defined: host-to-device data stage is emitted as described above.
  - Undefined: only the 8 SETUP bytes are sent; tx_last always falls on byte 7; the DATA state is not built; the wLength>8 rejection is removed; wLength is still transmitted in the SETUP bytes.

## Test plan
- Host-to-device request with data stage:
  - Stimulus: 0x21/0x02, wValue 0x0000, wIndex 0x0001, wLength 4, parameter_Block 0x…44332211, tx_ready=1.
  - Response: bytes 21 02 00 00 01 00 04 00 11 22 33 44; tx_last on 0x44; done in the cycle after the last transfer.
- Device-to-host request:
  - Stimulus: 0xA1/0x87, wLength 4.
  - Response: exactly 8 bytes A1 87 … 04 00; tx_last on the final 0x00; no data bytes.
- Backpressure:
  - Stimulus: case 1 with tx_ready low for 3 cycles on byte 5.
  - Response: tx_data=0x00 and tx_valid held stable for those 3 cycles; 12 transfers total, order unchanged.
- Rejection and busy behaviour:
  - Stimulus: 0x21 with wLength 9.
  - Response: err pulse at N+1; tx_valid never asserts.
  - Stimulus: start re-pulsed mid-request.
  - Response: ignored.
- Abort and reset:
  - Stimulus: abort after byte 3.
  - Response: tx_valid=0 next cycle; err pulse; no done.
  - Stimulus: async rst low mid-DATA.
  - Response: all outputs return to 0 immediately.
- Configuration off:
  - Stimulus: case 1 with CONTROL_TX_DATA_STAGE_EN undefined.
  - Response: 8 bytes only; tx_last on byte 7 (0x00); wLength 9 is not rejected.
